// File: rtl/ball_pkg.sv
// Shared constants and state type for the ball kinematics blocks.
// Positions and speeds are 32-bit signed fixed point with a 6-bit fraction.
package ball_pkg;

    localparam int unsigned COORD_W = 32;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int unsigned FIXED_SHIFT = $clog2(FIXED_POINT_MULTIPLIER);

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int BALL_W       = 32;
    localparam int BALL_H       = 32;
    localparam int GRAVITY      = 4;
    localparam int MAX_Y_SPEED  = 512;
    localparam int BOUNCE_SPEED = 400;
    localparam int BLINK_FRAMES = 16;

    // Largest top-left pixel coordinates that keep the ball on screen
    localparam int X_MAX = SCREEN_W - BALL_W;
    localparam int Y_MAX = SCREEN_H - BALL_H;

    localparam int unsigned BLINK_CNT_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DYING
    } ball_state_t;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Spawn/frame/hit inputs and position/status outputs of one ball.
// The master side (game logic) drives events; the slave side is the ball.
interface ball_motion_ctrl_if;
    import ball_pkg::*;

    logic                        startOfFrame;
    logic                        spawn;
    logic signed [COORD_W-1:0]   spawnX;
    logic signed [COORD_W-1:0]   spawnY;
    logic signed [COORD_W-1:0]   Xspeed_in;
    logic signed [COORD_W-1:0]   Yspeed_in;
    logic                        hit;

    logic signed [COORD_W-1:0]   topLeftX;
    logic signed [COORD_W-1:0]   topLeftY;
    logic                        ballActive;
    logic                        ballVisible;
    logic                        ballDone;

    modport master (
        output startOfFrame, spawn, spawnX, spawnY, Xspeed_in, Yspeed_in, hit,
        input  topLeftX, topLeftY, ballActive, ballVisible, ballDone
    );

    modport slave (
        input  startOfFrame, spawn, spawnX, spawnY, Xspeed_in, Yspeed_in, hit,
        output topLeftX, topLeftY, ballActive, ballVisible, ballDone
    );

endinterface

// File: rtl/ball_bounce_calc.sv
// Next-frame speeds from the current pixel position: wall reflection in X,
// floor/ceiling bounce plus gravity with a downward clamp in Y.
module ball_bounce_calc
    import ball_pkg::*;
(
    input  logic signed [COORD_W-1:0] pos_x,
    input  logic signed [COORD_W-1:0] pos_y,
    input  logic signed [COORD_W-1:0] xs,
    input  logic signed [COORD_W-1:0] ys,
    output logic signed [COORD_W-1:0] xs_next_c,
    output logic signed [COORD_W-1:0] ys_next_c
);

    logic signed [COORD_W-1:0] ys_grav;

    // Reflect X only when moving further into a side wall
    always_comb begin
        xs_next_c = xs;
        if ((pos_x <= 0 && xs < 0) || (pos_x >= X_MAX && xs > 0)) begin
            xs_next_c = -xs;
        end
    end

    // Floor bounce replaces gravity for that frame; ceiling bounce keeps it
    always_comb begin
        ys_grav   = ys + GRAVITY;
        ys_next_c = ys_grav;
        if (pos_y >= Y_MAX && ys > 0) begin
            ys_next_c = -BOUNCE_SPEED;
        end else if (pos_y <= 0 && ys < 0) begin
            ys_next_c = -ys + GRAVITY;
        end else if (ys_grav > MAX_Y_SPEED) begin
            ys_next_c = MAX_Y_SPEED;
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-ball kinematics: spawn latch, per-frame fixed-point integration with
// bounces, and a blinking death sequence that ends in a one-cycle done pulse.
module ball_motion_ctrl
    import ball_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    ball_motion_ctrl_if.slave    bus
);

    ball_state_t                 state_q, state_d;
    logic signed [COORD_W-1:0]   pos_x_q, pos_x_d;
    logic signed [COORD_W-1:0]   pos_y_q, pos_y_d;
    logic signed [COORD_W-1:0]   xs_q, xs_d;
    logic signed [COORD_W-1:0]   ys_q, ys_d;
    logic [BLINK_CNT_W-1:0]      blink_q, blink_d;
    logic                        visible_q, visible_d;
    logic                        active_q, active_d;
    logic                        done_q, done_d;

    logic signed [COORD_W-1:0]   pix_x, pix_y;
    logic signed [COORD_W-1:0]   xs_bnc, ys_bnc;

    assign pix_x = pos_x_q >>> FIXED_SHIFT;
    assign pix_y = pos_y_q >>> FIXED_SHIFT;

    ball_bounce_calc u_bounce (
        .pos_x     (pix_x),
        .pos_y     (pix_y),
        .xs        (xs_q),
        .ys        (ys_q),
        .xs_next_c (xs_bnc),
        .ys_next_c (ys_bnc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            xs_q      <= '0;
            ys_q      <= '0;
            blink_q   <= '0;
            visible_q <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            blink_q   <= blink_d;
            visible_q <= visible_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // The done pulse is raised while still in DYING, so a spawn in that cycle is dropped
    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        xs_d      = xs_q;
        ys_d      = ys_q;
        blink_d   = blink_q;
        visible_d = visible_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.spawn) begin
                    pos_x_d   = bus.spawnX * FIXED_POINT_MULTIPLIER;
                    pos_y_d   = bus.spawnY * FIXED_POINT_MULTIPLIER;
                    xs_d      = bus.Xspeed_in;
                    ys_d      = bus.Yspeed_in;
                    visible_d = 1'b1;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.hit) begin
                    blink_d   = '0;
                    visible_d = 1'b0;
                    state_d   = DYING;
                end else if (bus.startOfFrame) begin
                    xs_d    = xs_bnc;
                    ys_d    = ys_bnc;
                    pos_x_d = pos_x_q + xs_bnc;
                    pos_y_d = pos_y_q + ys_bnc;
                end
            end
            DYING: begin
                if (blink_q == BLINK_CNT_W'(BLINK_FRAMES)) begin
                    visible_d = 1'b0;
                    state_d   = IDLE;
                end else if (bus.startOfFrame) begin
                    blink_d   = blink_q + BLINK_CNT_W'(1);
                    visible_d = ~visible_q;
                    done_d    = (blink_d == BLINK_CNT_W'(BLINK_FRAMES));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    assign bus.topLeftX    = pix_x;
    assign bus.topLeftY    = pix_y;
    assign bus.ballActive  = active_q;
    assign bus.ballVisible = visible_q;
    assign bus.ballDone    = done_q;

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Per-ball kinematics stage directly downstream of the split-speed calculator. On a spawn pulse it latches the spawn position and the calculator's X/Y speeds. Once per video frame it integrates gravity and position in fixed point, with wall, floor and ceiling bounces. On a rope hit it blinks for a fixed number of frames, then retires and pulses done.

Parameters:
FIXED_POINT_MULTIPLIER, 64, fixed-point scale (power of 2; shift = 6)
SCREEN_W, 640, screen width in pixels
SCREEN_H, 480, screen height in pixels
BALL_W, 32, ball width in pixels
BALL_H, 32, ball height in pixels
GRAVITY, 4, Y speed increment per frame (fixed-point units)
MAX_Y_SPEED, 512, downward speed clamp
BOUNCE_SPEED, 400, upward speed magnitude after floor bounce
BLINK_FRAMES, 16, frames spent in DYING

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per video frame
spawn  in  1  one-cycle pulse: load ball
spawnX  in  32 (int)  spawn top-left X, pixels
spawnY  in  32 (int)  spawn top-left Y, pixels
Xspeed_in  in  32 (int)  initial X speed, fixed-point/frame, from speed calculator
Yspeed_in  in  32 (int)  initial Y speed, fixed-point/frame (negative = up)
hit  in  1  one-cycle collision pulse (rope/shot)
topLeftX  out  32 (int)  current X, pixels
topLeftY  out  32 (int)  current Y, pixels
ballActive  out  1  high in ACTIVE and DYING
ballVisible  out  1  drawing enable
ballDone  out  1  one-cycle pulse on DYING->IDLE

Behaviour:
- Reset: state IDLE; posX_fp, posY_fp, xs, ys, blink counter = 0; all outputs 0. Reset is asynchronous and may occur in any state, including mid-DYING.
- Outputs: topLeftX = posX_fp >>> 6 and topLeftY = posY_fp >>> 6. This is an arithmetic shift, so values floor. Both are registered.
- States are IDLE, ACTIVE, DYING.
- IDLE:
  - spawn -> next cycle: posX_fp = spawnX*64, posY_fp = spawnY*64, xs = Xspeed_in, ys = Yspeed_in; state ACTIVE.
  - hit and startOfFrame are ignored.
- ACTIVE: on startOfFrame, with the checks using the current pixel position and current speeds:
  - If x <= 0 and xs < 0, or x >= SCREEN_W-BALL_W and xs > 0: xs' = -xs. Otherwise xs' = xs.
  - If y >= SCREEN_H-BALL_H and ys > 0: ys' = -BOUNCE_SPEED (gravity is not applied this frame).
  - Else if y <= 0 and ys < 0: ys' = -ys + GRAVITY.
  - Else: ys' = min(ys + GRAVITY, MAX_Y_SPEED).
  - posX_fp += xs'; posY_fp += ys'. All updates land together one cycle after startOfFrame.
  - ballVisible = 1; ballActive = 1.
- hit in ACTIVE:
  - Next state DYING; blink counter = 0; position and speeds freeze.
  - hit has priority over a simultaneous startOfFrame, so no motion occurs that frame.
- DYING:
  - On each startOfFrame: counter++ and ballVisible toggles. ballVisible is 0 on entry.
  - When the counter reaches BLINK_FRAMES: state IDLE, ballDone = 1 for one cycle, ballActive = 0, ballVisible = 0.
  - spawn and hit are ignored.
- spawn outside IDLE is ignored. A spawn coinciding with the ballDone cycle is ignored (state is still DYING).
- All arithmetic is 32-bit signed. Overflow is not possible under the parameter limits, so there is no saturation except the Y clamp.

Decomposition:
- Shared package ball_pkg holds FIXED_POINT_MULTIPLIER, FIXED_SHIFT = 6, and typedef enum {IDLE, ACTIVE, DYING} ball_state_t.
- Sub-module ball_bounce_calc: combinational. It takes the current pixel position and speeds and returns xs' and ys'. It is reused by the player-shot block.
- The top level holds the FSM, the position/speed registers and the blink counter.

Test Plan:
- Reset mid-run: assert reset during ACTIVE at (300,200) -> same-cycle async clear; topLeftX/Y = 0, ballActive = 0, ballVisible = 0, ballDone = 0.
- Free flight: spawn (100,200), Xspeed_in = 64, Yspeed_in = -100, then one startOfFrame -> topLeftX = 101, ys = -96, posY_fp = 12704, topLeftY = 198.
- Right wall: spawn (608,100), xs = 64, ys = 0, one frame -> xs = -64, topLeftX = 607, ys = 4. Left wall mirror: spawn (0,100), xs = -64 -> topLeftX = 1.
- Floor bounce: spawn (200,448), ys = 50, one frame -> ys = -400, posY_fp = 28272, topLeftY = 441. Clamp: ys = 510 mid-air, one frame -> ys = 512.
- Hit and blink: hit coincident with startOfFrame at (150,150) -> position unchanged, DYING, ballVisible = 0. ballVisible toggles on each of the next 16 frames. On the 16th frame: ballDone pulses for exactly one cycle, then IDLE.
- Ignored events: spawn during ACTIVE leaves position and speeds unchanged; hit during IDLE leaves the state IDLE; spawn on the ballDone cycle is ignored, and a spawn one cycle later loads the ball.
